alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the accumulator-path ALU of the matrix-multiplier datapath.
- Adds:
  - a start/busy handshake;
  - a multi-cycle shift-add multiplier for the multiply-accumulate step;
  - carry/borrow/overflow flag;
  - explicit asynchronous reset.
- Sits between the register/operand muxes and the accumulator (AC).
- Its ac_load pulse is the write strobe for AC.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 4).
- MUL_ENABLE, 1, 1 = op 3 is the iterative multiplier; 0 = op 3 is a single-cycle op returning out=0, cflag=0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; sampled on the rising edge while busy=0.
- alu_control  input  3  opcode, sampled with start.
- in1  input  WIDTH  operand A, sampled with start.
- in2  input  WIDTH  operand B, sampled with start.
- out  output  WIDTH  registered result.
- zflag  output  1  result == 0, registered with out.
- cflag  output  1  carry / borrow / multiply overflow, registered with out.
- busy  output  1  multiply in progress.
- ac_load  output  1  one-cycle pulse: out/zflag/cflag hold a new result.

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, zflag=1, cflag=0, busy=0, ac_load=0, iteration counter=0, multiplier cleared. Release is synchronous to clk in effect; the first start is sampled on the first edge after release.
- Opcodes (all arithmetic modulo 2^WIDTH, unsigned):
  - 0 PASS: out=in2, cflag=0.
  - 1 ADD: out=in1+in2, cflag=carry out.
  - 2 SUB: out=in1-in2, cflag=borrow (in1<in2).
  - 3 MUL: out=low WIDTH bits of in1*in2, cflag=1 iff high WIDTH bits nonzero.
  - 4 INC: out=in1+1, cflag=carry.
  - 5 DEC: out=in1-1, cflag=borrow (in1==0).
  - 6 AND: out=in1&in2, cflag=0.
  - 7 SHR: out=in1>>1, cflag=in1[0].
- States: IDLE, MUL.
- IDLE, start=1, op!=3 (or MUL_ENABLE=0):
  - result, zflag and cflag are written on that same edge;
  - ac_load=1 for exactly the following cycle;
  - FSM stays in IDLE, so back-to-back single-cycle ops are accepted on every edge.
- IDLE, start=1, op=3, MUL_ENABLE=1:
  - latch operands into a 2*WIDTH product register and multiplier shift register;
  - counter=0, busy=1, go to MUL;
  - out and flags hold their old values.
- MUL: one shift-add iteration per edge.
  - On the WIDTH-th iteration edge (WIDTH edges after the accepting edge), write out, zflag and cflag; pulse ac_load for one cycle; busy=0; return to IDLE.
  - 16-bit latency: accepted at edge k, result and ac_load visible after edge k+16.
- start while busy=1: ignored, with no queuing and no effect on operands or result. A new start is first accepted on the edge after busy falls.
- ac_load is never high in two consecutive cycles for one operation, and is never high with busy=1.
- zflag is evaluated on the truncated WIDTH-bit out.
- Flags and out hold between results; no opcode changes them without ac_load.
- Reset mid-multiply: aborts immediately to reset values; no ac_load is produced.
- Opcode or operand changes after acceptance have no effect on the operation in flight.

Test Plan:
- Reset, then start ADD in1=5 in2=7 -> after one edge out=12, zflag=0, cflag=0, ac_load pulse of 1 cycle, busy stays 0.
- SUB in1=3 in2=10 -> out=0xFFF9, cflag=1, zflag=0. Then SUB in1=9 in2=9 -> out=0, zflag=1, cflag=0.
- MUL in1=3 in2=10 -> busy=1 for 16 cycles, out=30, cflag=0, ac_load exactly once on the cycle busy falls. Meanwhile ADD starts during busy are ignored: out stays unchanged until the MUL result.
- MUL in1=0x0100 in2=0x0100 -> out=0, zflag=1, cflag=1. Then MUL 0xFFFF*0xFFFF -> out=0x0001, cflag=1.
- Back-to-back single-cycle ops:
  - INC 0xFFFF, then DEC 0, then SHR 5 on consecutive edges -> (0,z=1,c=1), (0xFFFF,c=1), (2,c=1);
  - three ac_load pulses on consecutive cycles.
- Assert rst_n=0 at iteration 8 of a MUL -> outputs return to reset values immediately, no ac_load; a MUL started after release completes normally. Repeat the suite with WIDTH=8 and MUL_ENABLE=0 (op 3 -> out=0 in 1 cycle).

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered accumulator-path ALU with a start/busy handshake.
// Single-cycle ops are written on the accepting edge. MUL (when enabled) runs
// an iterative shift-add over WIDTH edges. ac_load pulses for one cycle with
// each new result and acts as the write strobe for AC.
module alu_seq #(
    parameter int WIDTH      = 16,
    parameter int MUL_ENABLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             zflag,
    output logic             cflag,
    output logic             busy,
    output logic             ac_load
);

    localparam int CW  = $clog2(WIDTH);
    localparam int WP1 = WIDTH + 1;

    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [WIDTH:0] ONE_W     = WP1'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_INC  = 3'd4;
    localparam logic [2:0] OP_DEC  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // {partial-product high half, multiplier shifting out of the low half}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zflag_q, zflag_d;
    logic               cflag_q, cflag_d;
    logic               ac_load_q, ac_load_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     wide;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic               is_mul;

    // Single-cycle datapath; the extra top bit of 'wide' is carry/borrow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        case (alu_control)
            OP_PASS: alu_res = in2;
            OP_ADD: begin
                wide    = {1'b0, in1} + {1'b0, in2};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SUB: begin
                wide    = {1'b0, in1} - {1'b0, in2};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_MUL: begin
                // Only reached when the iterative multiplier is disabled.
                alu_res = '0;
                alu_c   = 1'b0;
            end
            OP_INC: begin
                wide    = {1'b0, in1} + ONE_W;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_DEC: begin
                wide    = {1'b0, in1} - ONE_W;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_AND: alu_res = in1 & in2;
            OP_SHR: begin
                alu_res = in1 >> 1;
                alu_c   = in1[0];
            end
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift the whole register right (carry enters at the top).
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mcand_q} : {WP1{1'b0}});
        acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    assign is_mul = (MUL_ENABLE != 0) && (alu_control == OP_MUL);

    // Control FSM and result/flag next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        out_d     = out_q;
        zflag_d   = zflag_q;
        cflag_d   = cflag_q;
        ac_load_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        acc_d   = {{WIDTH{1'b0}}, in2};
                        mcand_d = in1;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        out_d     = alu_res;
                        zflag_d   = (alu_res == '0);
                        cflag_d   = alu_c;
                        ac_load_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    out_d     = acc_step[WIDTH-1:0];
                    zflag_d   = (acc_step[WIDTH-1:0] == '0);
                    cflag_d   = |acc_step[2*WIDTH-1:WIDTH];
                    ac_load_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any multiply in flight without ac_load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            out_q     <= '0;
            zflag_q   <= 1'b1;
            cflag_q   <= 1'b0;
            ac_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            out_q     <= out_d;
            zflag_q   <= zflag_d;
            cflag_q   <= cflag_d;
            ac_load_q <= ac_load_d;
        end
    end

    assign out     = out_q;
    assign zflag   = zflag_q;
    assign cflag   = cflag_q;
    assign busy    = (state_q == S_MUL);
    assign ac_load = ac_load_q;

endmodule
